tanh_lut_loader: RTL and testbench

TANH_LUT_LOADER -- requirements
Module: tanh_lut_loader

---
 rtl/tanh_lut_loader.sv | 81 ++++++++
 tb/tb_tanh_lut_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tanh_lut_loader.sv
// tanh_lut_loader: streams a DEPTH-entry tanh table into local storage and serves 1-cycle lookups from it
module tanh_lut_loader #(
    parameter int DEPTH = 352,
    parameter int WIDTH = 18,
    parameter int BASE  = 512,
    parameter int SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             busy,
    output logic             load_done,
    input  logic             lk_valid,
    input  logic [WIDTH-1:0] lk_x,
    output logic [WIDTH-1:0] lk_y,
    output logic             lk_y_valid,
    output logic             lk_miss
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [WIDTH-1:0] BASE_W = WIDTH'(BASE);
    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    state_t state;
    logic [AW-1:0] addr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] off;
    logic [AW-1:0] idx;
    assign s_ready = state == LOAD;
    // clamp the magnitude onto the table: below BASE -> first entry, beyond the end -> last entry
    always_comb begin
        off = (lk_x - BASE_W) >> SHIFT;
        idx = lk_x < BASE_W ? '0 : off >= DEPTH_W ? LAST : off[AW-1:0];
    end
    // load sequencer: start (outside LOAD) rewinds the write pointer, the last accept publishes the table
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            busy      <= 1'b0;
            load_done <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state     <= LOAD;
                    addr      <= '0;
                    busy      <= 1'b1;
                    load_done <= 1'b0;
                end
                LOAD: if (s_valid) begin
                    addr <= addr + AW'(1);
                    if (addr == LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        load_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    // table storage has no reset; a write needs an accepted entry and no reset this cycle
    always_ff @(posedge clk) begin
        if (!rst && state == LOAD && s_valid) mem[addr] <= s_data;
    end
    // lookup pipeline: one result per request, zero with miss flagged while no complete table is held
    always_ff @(posedge clk) begin
        if (rst) begin
            lk_y       <= '0;
            lk_y_valid <= 1'b0;
            lk_miss    <= 1'b0;
        end else begin
            lk_y       <= lk_valid && load_done ? mem[idx] : '0;
            lk_y_valid <= lk_valid;
            lk_miss    <= lk_valid && !load_done;
        end
    end
endmodule

// File: tb/tb_tanh_lut_loader.sv
// tb_tanh_lut_loader: randomized scoreboard bench for tanh_lut_loader against a table-level model
module tb_tanh_lut_loader;
    localparam int DEPTH = 352;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic s_valid = 1'b0;
    logic s_ready;
    logic [17:0] s_data = '0;
    logic busy, load_done;
    logic lk_valid = 1'b0;
    logic [17:0] lk_x = '0;
    logic [17:0] lk_y;
    logic lk_y_valid, lk_miss;

    tanh_lut_loader dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .busy(busy), .load_done(load_done), .lk_valid(lk_valid),
        .lk_x(lk_x), .lk_y(lk_y), .lk_y_valid(lk_y_valid), .lk_miss(lk_miss)
    );

    always #5 clk = ~clk;

    typedef struct {logic [17:0] y; logic miss;} exp_t;
    exp_t q[$];
    logic [17:0] m_tbl [DEPTH];
    bit m_loading = 0, m_done = 0, mon_en = 0;
    int m_cnt = 0;
    int errors = 0, checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lut_index(input int x);
        int d;
        if (x < 512) return 0;
        d = (x - 512) / 16;
        return d > DEPTH - 1 ? DEPTH - 1 : d;
    endfunction

    // one clock: let the DUT sample the driven inputs, advance the model, then clear pulses
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        if (rst) begin
            m_loading = 0;
            m_done = 0;
            m_cnt = 0;
        end else begin
            if (lk_valid) begin
                e.y = m_done ? m_tbl[lut_index(int'(lk_x))] : 18'd0;
                e.miss = !m_done;
                q.push_back(e);
            end
            if (m_loading) begin
                if (s_valid) begin
                    m_tbl[m_cnt] = s_data;
                    m_cnt++;
                    if (m_cnt == DEPTH) begin
                        m_loading = 0;
                        m_done = 1;
                    end
                end
            end else if (start) begin
                m_loading = 1;
                m_cnt = 0;
                m_done = 0;
            end
        end
        #1;
        start = 0;
        s_valid = 0;
        lk_valid = 0;
        rst = 0;
    endtask

    task automatic rand_lookup();
        lk_valid = 1'($urandom_range(0, 1));
        lk_x = $urandom_range(0, 3) == 0 ? 18'($urandom) : 18'($urandom_range(0, 8191));
    endtask

    task automatic lookup(input int x);
        lk_valid = 1;
        lk_x = 18'(x);
        cyc();
    endtask

    // monitor: every cycle compare status outputs with the model and pop the scoreboard on results
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            chk("busy", int'(busy), int'(m_loading));
            chk("s_ready", int'(s_ready), int'(m_loading));
            chk("load_done", int'(load_done), int'(m_done));
            chk("lk_y_valid", int'(lk_y_valid), int'(q.size() > 0));
            if (lk_y_valid && q.size() > 0) begin
                e = q.pop_front();
                chk("lk_y", int'(lk_y), int'(e.y));
                chk("lk_miss", int'(lk_miss), int'(e.miss));
            end else if (!lk_y_valid) begin
                chk("lk_miss_idle", int'(lk_miss), 0);
            end
        end
    end

    initial begin
        rst = 1;
        lk_valid = 1;
        start = 1;
        cyc();
        mon_en = 1;
        rst = 1;
        cyc();
        @(negedge clk);
        chk("reset_lk_y", int'(lk_y), 0);
        #1;
        lookup(1024);
        cyc();
        start = 1;
        cyc();
        for (int i = 0; i < DEPTH; i++) begin
            s_valid = 1;
            s_data = 18'(i * 4);
            rand_lookup();
            cyc();
        end
        s_valid = 1;
        s_data = 18'd99;
        cyc();
        lookup(512);
        lookup(1024);
        lookup(6143);
        lookup(6144);
        lookup(100);
        for (int i = 0; i < 150; i++) begin
            rand_lookup();
            cyc();
        end
        start = 1;
        lookup(1024);
        for (int i = 0; i < 703; i++) begin
            s_valid = (i % 2) == 0;
            s_data = 18'($urandom);
            rand_lookup();
            cyc();
        end
        for (int i = 0; i < 200; i++) begin
            rand_lookup();
            cyc();
        end
        start = 1;
        cyc();
        for (int i = 0; i < 100; i++) begin
            s_valid = 1;
            s_data = 18'($urandom);
            cyc();
        end
        rst = 1;
        s_valid = 1;
        lk_valid = 1;
        start = 1;
        cyc();
        lookup(2000);
        start = 1;
        cyc();
        for (int i = 0; i < DEPTH; i++) begin
            s_valid = 1;
            s_data = 18'd7;
            cyc();
        end
        for (int i = 0; i < 100; i++) begin
            lk_valid = 1;
            lk_x = 18'($urandom);
            cyc();
        end
        start = 1;
        cyc();
        for (int i = 0; i < DEPTH; i++) begin
            s_valid = 1;
            s_data = 18'($urandom);
            start = i == 200;
            rand_lookup();
            cyc();
        end
        for (int i = 0; i < 100; i++) begin
            rand_lookup();
            cyc();
        end
        cyc();
        cyc();
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
